// File: rtl/i2s_rx_stereo.sv
// I2S / left-justified serial audio receiver: oversamples bclk, lrclk and sd in the clk domain,
// deserialises each slot MSB-first and emits aligned left/right pairs with a one-cycle valid strobe.
module i2s_rx_stereo #(
    parameter int w_des       = 24,
    parameter int stereo      = 1,
    parameter int fmt         = 0,
    parameter int left_lvl    = 0,
    parameter int sync_stages = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bclk,
    input  logic             lrclk,
    input  logic             sd,
    output logic [w_des-1:0] left,
    output logic [w_des-1:0] right,
    output logic             valid,
    output logic             slot_err
);

    localparam int cnt_w = $clog2(w_des + 1);
    localparam logic [cnt_w-1:0] cnt_full = cnt_w'(w_des);

    logic [sync_stages-1:0] bclk_sync_q, lr_sync_q, sd_sync_q;
    logic                   bclk_prev_q;
    logic                   lr_eff_q, lr_eff_d;
    logic                   lr_prev_q, lr_prev_d;
    logic [cnt_w-1:0]       cnt_q, cnt_d;
    logic [w_des-1:0]       shift_q, shift_d;
    logic [w_des-1:0]       left_hold_q, left_hold_d;
    logic                   locked_q, locked_d;
    logic                   have_left_q, have_left_d;
    logic [w_des-1:0]       left_q, left_d;
    logic [w_des-1:0]       right_q, right_d;
    logic                   valid_q, valid_d;
    logic                   slot_err_q, slot_err_d;

    logic bclk_s, lr_s, sd_s;
    logic rise, lr_eff, boundary;

    assign bclk_s = bclk_sync_q[sync_stages-1];
    assign lr_s   = lr_sync_q[sync_stages-1];
    assign sd_s   = sd_sync_q[sync_stages-1];

    assign rise     = bclk_s & ~bclk_prev_q;
    // In Philips mode the word select seen at the previous rise absorbs the one-bclk MSB delay.
    assign lr_eff   = (fmt == 1) ? lr_s : lr_eff_q;
    assign boundary = rise && (lr_eff != lr_prev_q);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path through the branches infers a latch.
        lr_eff_d    = lr_eff_q;
        lr_prev_d   = lr_prev_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        locked_d    = locked_q;
        have_left_d = have_left_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        slot_err_d  = 1'b0;

        if (rise) begin
            lr_eff_d  = lr_s;
            lr_prev_d = lr_eff;
            if (boundary) begin
                if (locked_q) begin
                    slot_err_d = (cnt_q < cnt_full);
                    if (lr_prev_q == 1'(left_lvl)) begin
                        if (stereo == 1) begin
                            left_hold_d = shift_q;
                            have_left_d = 1'b1;
                        end else begin
                            left_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else if ((stereo == 1) && have_left_q) begin
                        left_d      = left_hold_q;
                        right_d     = shift_q;
                        valid_d     = 1'b1;
                        have_left_d = 1'b0;
                    end
                end
                locked_d = 1'b1;
                shift_d  = w_des'(sd_s) << (w_des - 1);
                cnt_d    = cnt_w'(1);
            end else if (cnt_q < cnt_full) begin
                shift_d = shift_q | (w_des'(sd_s) << (cnt_w'(w_des - 1) - cnt_q));
                cnt_d   = cnt_q + cnt_w'(1);
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            lr_eff_q    <= 1'b0;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            locked_q    <= 1'b0;
            have_left_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            slot_err_q  <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[sync_stages-2:0], bclk};
            lr_sync_q   <= {lr_sync_q[sync_stages-2:0], lrclk};
            sd_sync_q   <= {sd_sync_q[sync_stages-2:0], sd};
            bclk_prev_q <= bclk_s;
            lr_eff_q    <= lr_eff_d;
            lr_prev_q   <= lr_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            locked_q    <= locked_d;
            have_left_q <= have_left_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            slot_err_q  <= slot_err_d;
        end
    end

    assign left     = left_q;
    assign right    = right_q;
    assign valid    = valid_q;
    assign slot_err = slot_err_q;

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Bench for i2s_rx_stereo: three configurations share one pin stream; a slot-level model predicts every pulse.
module tb_i2s_rx_stereo;

    localparam int W = 24;
    localparam int N = 3;
    // inst0: stereo Philips left=0; inst1: stereo left-justified left=1; inst2: mono left-justified left=0
    localparam int cfg_fmt [N] = '{0, 1, 1};
    localparam int cfg_ste [N] = '{1, 1, 0};
    localparam int cfg_lvl [N] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bclk = 1'b0;
    logic lrclk = 1'b0;
    logic sd = 1'b0;
    logic [W-1:0] left_o [N];
    logic [W-1:0] right_o [N];
    logic         valid_o [N];
    logic         err_o [N];

    always #5 clk = ~clk;

    i2s_rx_stereo #(.w_des(W), .stereo(1), .fmt(0), .left_lvl(0), .sync_stages(2)) u_a (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sd(sd),
        .left(left_o[0]), .right(right_o[0]), .valid(valid_o[0]), .slot_err(err_o[0]));
    i2s_rx_stereo #(.w_des(W), .stereo(1), .fmt(1), .left_lvl(1), .sync_stages(3)) u_b (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sd(sd),
        .left(left_o[1]), .right(right_o[1]), .valid(valid_o[1]), .slot_err(err_o[1]));
    i2s_rx_stereo #(.w_des(W), .stereo(0), .fmt(1), .left_lvl(0), .sync_stages(2)) u_c (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sd(sd),
        .left(left_o[2]), .right(right_o[2]), .valid(valid_o[2]), .slot_err(err_o[2]));

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (slot level) ----------------
    typedef struct {
        logic         v;
        logic         e;
        logic [W-1:0] l;
        logic [W-1:0] r;
    } ev_t;

    ev_t          exp_q [N][$];
    logic         slot_bits [N][$];
    logic         m_pin_prev [N];
    logic         m_lr_prev [N];
    logic         m_locked [N];
    logic         m_have [N];
    logic [W-1:0] m_hold [N];
    logic [W-1:0] m_cur_l [N];
    logic [W-1:0] m_cur_r [N];

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            slot_bits[k].delete();
            m_pin_prev[k] = 1'b0;
            m_lr_prev[k]  = 1'b0;
            m_locked[k]   = 1'b0;
            m_have[k]     = 1'b0;
            m_hold[k]     = '0;
            m_cur_l[k]    = '0;
            m_cur_r[k]    = '0;
        end
    endtask

    task automatic model_commit(input int k);
        logic [W-1:0] word;
        ev_t ev;
        word = '0;
        for (int i = 0; i < W && i < slot_bits[k].size(); i++) word[W-1-i] = slot_bits[k][i];
        ev.v = 1'b0;
        ev.e = (slot_bits[k].size() < W);
        if (int'(m_lr_prev[k]) == cfg_lvl[k]) begin
            if (cfg_ste[k] == 1) begin
                m_hold[k] = word;
                m_have[k] = 1'b1;
            end else begin
                m_cur_l[k] = word;
                ev.v = 1'b1;
            end
        end else if (cfg_ste[k] == 1 && m_have[k]) begin
            m_cur_l[k] = m_hold[k];
            m_cur_r[k] = word;
            m_have[k]  = 1'b0;
            ev.v = 1'b1;
        end
        ev.l = m_cur_l[k];
        ev.r = m_cur_r[k];
        if (ev.v || ev.e) exp_q[k].push_back(ev);
    endtask

    task automatic model_rise(input logic lr, input logic sdv);
        logic eff;
        for (int k = 0; k < N; k++) begin
            eff = (cfg_fmt[k] == 1) ? lr : m_pin_prev[k];
            m_pin_prev[k] = lr;
            if (eff != m_lr_prev[k]) begin
                if (m_locked[k]) model_commit(k);
                m_locked[k] = 1'b1;
                m_lr_prev[k] = eff;
                slot_bits[k].delete();
            end
            slot_bits[k].push_back(sdv);
        end
    endtask

    // ---------------- output monitor ----------------
    int           nvalid [N];
    int           nerr [N];
    logic [W-1:0] last_left [N];
    logic [W-1:0] last_right [N];
    logic [W-1:0] left_log [N][$];

    always @(negedge clk) begin
        ev_t x;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (valid_o[k] || err_o[k]) begin
                    if (exp_q[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pulse inst%0d: got v=%b e=%b expected no pulse", k, valid_o[k], err_o[k]);
                    end else begin
                        x = exp_q[k].pop_front();
                        check($sformatf("pulse_inst%0d", k),
                              64'({valid_o[k], err_o[k], left_o[k], right_o[k]}),
                              64'({x.v, x.e, x.l, x.r}));
                    end
                    if (valid_o[k]) begin
                        nvalid[k]++;
                        last_left[k]  = left_o[k];
                        last_right[k] = right_o[k];
                        left_log[k].push_back(left_o[k]);
                    end
                    if (err_o[k]) nerr[k]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct packed {
        logic lr;
        logic sd;
    } bit_t;
    bit_t stream[$];

    task automatic add_slot(input logic lv, input int n, input logic [63:0] d);
        for (int i = n - 1; i >= 0; i--) stream.push_back({lv, d[i]});
    endtask

    // The queue holds left-justified framing; in Philips mode lrclk is driven one bit early.
    task automatic play(input bit i2s, input int hmin, input int hmax);
        for (int i = 0; i < stream.size(); i++) begin
            int h;
            logic lr;
            lr = (i2s && (i + 1 < stream.size())) ? stream[i+1].lr : stream[i].lr;
            h = $urandom_range(hmax, hmin);
            @(negedge clk);
            bclk = 1'b0;
            lrclk = lr;
            sd = stream[i].sd;
            repeat (h) @(negedge clk);
            bclk = 1'b1;
            model_rise(lr, stream[i].sd);
            repeat (h) @(negedge clk);
        end
        @(negedge clk);
        bclk = 1'b0;
        stream.delete();
    endtask

    task automatic drain();
        repeat (12) @(negedge clk);
    endtask

    // Asserts reset between clk edges and checks that outputs clear without waiting for a clock.
    task automatic hw_reset();
        @(negedge clk);
        bclk = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++)
            check($sformatf("reset_outputs_inst%0d", k),
                  64'({left_o[k], right_o[k], valid_o[k], err_o[k]}), 64'd0);
        model_clear();
        for (int k = 0; k < N; k++) begin
            nvalid[k] = 0;
            nerr[k] = 0;
            last_left[k] = '0;
            last_right[k] = '0;
            left_log[k].delete();
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        string        name;
        int           inst;
        int           n;
        logic [63:0]  l;
        logic [63:0]  r;
        logic [W-1:0] el;
        logic [W-1:0] er;
        int           ev;
        int           ee;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"nominal_i2s",   0, 24, 64'hA5A5A5,   64'h123456,   24'hA5A5A5, 24'h123456, 1, 0};
        vecs[1] = '{"truncate_lj",   1, 32, 64'hDEADBEEF, 64'h01234567, 24'hDEADBE, 24'h012345, 1, 0};
        vecs[2] = '{"short_16",      0, 16, 64'hBEEF,     64'h8001,     24'hBEEF00, 24'h800100, 1, 2};
        vecs[3] = '{"one_bit_slots", 0, 1,  64'h1,        64'h0,        24'h800000, 24'h000000, 1, 2};
        vecs[4] = '{"exact_24_lj",   1, 24, 64'hFFFFFF,   64'h000001,   24'hFFFFFF, 24'h000001, 1, 0};
        vecs[5] = '{"slot_25",       0, 25, 64'h1ABCDEF,  64'h0000001,  24'hD5E6F7, 24'h000000, 1, 0};
        vecs[6] = '{"slot_23_lj",    1, 23, 64'h7FFFFF,   64'h000001,   24'hFFFFFE, 24'h000002, 1, 2};

        model_clear();
        for (int k = 0; k < N; k++) begin
            nvalid[k] = 0;
            nerr[k] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table: orphan right slot first (dropped), then one L/R pair, then a short left slot to close it.
        foreach (vecs[i]) begin
            int  k;
            logic lv;
            k = vecs[i].inst;
            lv = 1'(cfg_lvl[k]);
            hw_reset();
            add_slot(~lv, 32, {$urandom, $urandom});
            add_slot(lv, vecs[i].n, vecs[i].l);
            add_slot(~lv, vecs[i].n, vecs[i].r);
            add_slot(lv, 3, 64'h5);
            play(cfg_fmt[k] == 0, 2, 3);
            drain();
            check({vecs[i].name, "_valid_count"}, 64'(nvalid[k]), 64'(vecs[i].ev));
            check({vecs[i].name, "_err_count"}, 64'(nerr[k]), 64'(vecs[i].ee));
            check({vecs[i].name, "_left"}, 64'(last_left[k]), 64'(vecs[i].el));
            check({vecs[i].name, "_right"}, 64'(last_right[k]), 64'(vecs[i].er));
        end

        // Mono: three frames, right-slot data must never reach the outputs.
        hw_reset();
        add_slot(1'b1, 24, 64'hFFFFFF);
        for (int f = 1; f <= 3; f++) begin
            add_slot(1'b0, 24, 64'(f));
            add_slot(1'b1, 24, 64'($urandom));
        end
        add_slot(1'b0, 2, 64'h0);
        play(1'b0, 2, 3);
        drain();
        check("mono_valid_count", 64'(nvalid[2]), 64'd3);
        for (int f = 0; f < 3; f++)
            check($sformatf("mono_left_%0d", f + 1),
                  (left_log[2].size() > f) ? 64'(left_log[2][f]) : 64'hBAD, 64'(f + 1));
        check("mono_right_zero", 64'(last_right[2]), 64'd0);
        check("mono_err_count", 64'(nerr[2]), 64'd0);

        // Mid-frame reset on 32-bit Philips slots: partial slot and the next slot are discarded.
        hw_reset();
        add_slot(1'b1, 32, 64'hFFFF0000);
        add_slot(1'b0, 32, 64'h11223344);
        add_slot(1'b1, 32, 64'h55667788);
        add_slot(1'b0, 10, 64'h3A5);
        play(1'b1, 2, 3);
        drain();
        check("pre_reset_valid_count", 64'(nvalid[0]), 64'd1);
        check("pre_reset_pair", 64'({last_left[0], last_right[0]}), 64'({24'h112233, 24'h556677}));
        hw_reset();
        add_slot(1'b0, 22, 64'h2ABCD);
        add_slot(1'b1, 32, 64'h99999999);
        add_slot(1'b0, 32, 64'hCAFEF00D);
        add_slot(1'b1, 32, 64'h0BADC0DE);
        add_slot(1'b0, 3, 64'h0);
        play(1'b1, 2, 3);
        drain();
        check("post_reset_valid_count", 64'(nvalid[0]), 64'd1);
        check("post_reset_pair", 64'({last_left[0], last_right[0]}), 64'({24'hCAFEF0, 24'h0BADC0}));

        // Randomized slots of 1..34 bits, both framings, checked by the model on all instances.
        for (int pass = 0; pass < 2; pass++) begin
            logic lv;
            hw_reset();
            lv = 1'($urandom);
            for (int s = 0; s < 70; s++) begin
                add_slot(lv, $urandom_range(34, 1), {$urandom, $urandom});
                lv = ~lv;
            end
            play(pass == 0, 2, 4);
            drain();
            for (int k = 0; k < N; k++)
                check($sformatf("random%0d_drained_inst%0d", pass, k), 64'(exp_q[k].size()), 64'd0);
            check($sformatf("random%0d_activity", pass), 64'(nvalid[0] > 0 && nvalid[2] > 0), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_rx_stereo.md
Name: i2s_rx_stereo

Overview:
- Parametrised next-generation I2S/left-justified serial audio receiver, with two channels or left-only.
- Oversamples bclk, lrclk and sd in the system clock domain and deserialises each slot MSB-first into a w_des-bit word.
- Presents left/right samples as an aligned pair with a one-cycle valid strobe and reports short slots.
- Sits between the external ADC/codec pins and the bit-serial processing core.

Parameters:
- w_des, 24: output word width in bits; slot widths from 1 up to any value are accepted.
- stereo, 1: 1 = left+right pair output; 0 = left channel only.
- fmt, 0: 0 = Philips I2S (MSB one bclk after lrclk change); 1 = left-justified (MSB on the lrclk change).
- left_lvl, 0: lrclk level that denotes the left channel.
- sync_stages, 2: flip-flop depth of the input synchronisers, minimum 2.

Ports:
- clk, input, 1: system clock; must give at least 2 clk periods in each bclk phase.
- rst_n, input, 1: asynchronous active-low reset.
- bclk, input, 1: serial bit clock, asynchronous to clk.
- lrclk, input, 1: word select, asynchronous.
- sd, input, 1: serial data, asynchronous.
- left, output, w_des: left sample, registered.
- right, output, w_des: right sample, registered; held 0 when stereo=0.
- valid, output, 1: one-clk pulse when left/right update.
- slot_err, output, 1: one-clk pulse when a committed slot carried fewer than w_des bits.

Behaviour:
- Reset:
  - rst_n low forces, asynchronously: left=0, right=0, valid=0, slot_err=0, all synchroniser flops=0, bclk_prev=0, lr_eff/lr_prev=0, bit counter=0, shift=0, left_hold=0, locked=0, have_left=0.
  - Mid-frame reset discards the partial slot. The first slot after reset is never output.
- Sampling:
  - bclk, lrclk and sd each pass through sync_stages flip-flops.
  - A bclk rising edge ("rise") is synchronised bclk=1 with bclk_prev=0. All capture happens only on rise. Falling edges are ignored.
- Effective word select:
  - fmt=1: lr_eff equals lrclk sampled at this rise.
  - fmt=0: lr_eff equals lrclk sampled at the previous rise, which absorbs the one-bclk I2S delay. All logic below uses lr_eff.
- Slot boundary: a rise where lr_eff differs from the lr_eff of the previous rise.
- At a boundary, in this order:
  - (a) Commit the finished slot if locked=1.
  - (b) Set locked=1.
  - (c) Start the new slot: shift is cleared, sd is written to bit w_des-1, and the counter is set to 1.
- Non-boundary rise:
  - If counter < w_des: sd is written to bit (w_des-1-counter) and the counter increments.
  - Otherwise the bit is discarded; the counter saturates at w_des. This truncates LSBs of wider slots.
  - Counter width is $clog2(w_des+1).
- Commit of a left slot (previous lr_eff == left_lvl):
  - stereo=1: left_hold <= shift; have_left=1. No valid.
  - stereo=0: left <= shift; valid pulses.
- Commit of a right slot (stereo=1):
  - Only if have_left=1: left <= left_hold; right <= shift; valid pulses; have_left cleared.
  - A right slot without a preceding left slot is dropped silently.
- Zero padding: a slot with fewer than w_des bits is committed with zero-padded LSBs. slot_err pulses in the same cycle as the commit, whether or not valid fires.
- Timing of outputs: left, right, valid and slot_err update on the clk edge that registers the boundary rise. Pin-to-valid latency is sync_stages+1 clk after the bclk pin edge.
- Fixed-level lrclk: if lrclk never toggles, there are no commits and no valid.
- Simultaneous events: a boundary and a counter saturation on the same rise are resolved by the boundary (restart). The commit uses the count before restart.

Test Plan:
- Reset behaviour: w_des=24, stereo=1, fmt=0, 32-bit slots; pulse rst_n low for 3 clk mid-frame -> all outputs 0 immediately; first valid only after one full discarded slot plus a complete L/R pair.
- Nominal I2S pair: fmt=0, 24-bit slots; send L=0xA5A5A5, R=0x123456 -> single valid with left=0xA5A5A5, right=0x123456, slot_err=0.
- Truncation: fmt=1, left_lvl=1, 32-bit slots; send L=0xDEADBEEF, R=0x01234567 -> left=0xDEADBE, right=0x012345, no slot_err.
- Short slot: w_des=24, 16-bit slots; send L=0xBEEF, R=0x8001 -> left=0xBEEF00, right=0x800100, slot_err pulses at both commits, valid once.
- Mono mode: stereo=0; three frames with L=1,2,3 -> three valid pulses with left=1,2,3; right stays 0; right-slot data ignored.
- Lock-in: start the stream on a right slot after reset -> first valid comes only after the next complete left+right pair; the orphan right slot is dropped.
